// File: rtl/div_core_if.sv
// Operand/result bundle between the divider and its register bank.
// The err signal exists only when DIV_ZERO_CHK_EN is defined.
interface div_core_if #(
    parameter int WIDTH = 16
);
    logic             init;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
`ifdef DIV_ZERO_CHK_EN
    logic             err;

    modport master (output init, A, B, input  busy, done, quot, rem, err);
    modport slave  (input  init, A, B, output busy, done, quot, rem, err);
`else
    modport master (output init, A, B, input  busy, done, quot, rem);
    modport slave  (input  init, A, B, output busy, done, quot, rem);
`endif
endinterface

// File: rtl/div_core.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Optional early divide-by-zero exit with err flag: define DIV_ZERO_CHK_EN.
module div_core #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    div_core_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH:0]   r_q;
    logic [CW-1:0]    count_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
`ifdef DIV_ZERO_CHK_EN
    logic             zero_q;
    logic             err_q;
`endif

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   trial;
    logic             fits;

    // Partial remainder stays below the divisor, so the top bit of shifted is
    // always zero; the full-width compare keeps the trial subtract borrow-free.
    assign shifted = {r_q, q_q[WIDTH-1]};
    assign fits    = shifted >= {2'b00, d_q};
    assign trial   = shifted[WIDTH:0] - {1'b0, d_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.init) state_d = LOAD;
            LOAD: begin
`ifdef DIV_ZERO_CHK_EN
                if (bus.B == '0) state_d = DONE;
                else             state_d = CALC;
`else
                state_d = CALC;
`endif
            end
            CALC: if (count_q == CW'(1)) state_d = DONE;
            DONE: if (bus.init) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef DIV_ZERO_CHK_EN
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    q_q     <= bus.A;
                    d_q     <= bus.B;
                    r_q     <= '0;
                    count_q <= CW'(WIDTH);
`ifdef DIV_ZERO_CHK_EN
                    zero_q  <= (bus.B == '0);
                    if (bus.B == '0) begin
                        q_q <= '1;
                        r_q <= {1'b0, bus.A};
                    end
`endif
                end
                CALC: begin
                    count_q <= count_q - 1'b1;
                    if (fits) begin
                        r_q <= trial;
                        q_q <= {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_q <= shifted[WIDTH:0];
                        q_q <= {q_q[WIDTH-2:0], 1'b0};
                    end
                end
                DONE: begin
                    // Results are published one edge after entering DONE and
                    // held until the next completion or reset.
                    if (bus.init) begin
                        done_q <= 1'b0;
`ifdef DIV_ZERO_CHK_EN
                        err_q  <= 1'b0;
`endif
                    end else begin
                        done_q <= 1'b1;
                        quot_q <= q_q;
                        rem_q  <= r_q[WIDTH-1:0];
`ifdef DIV_ZERO_CHK_EN
                        err_q  <= zero_q;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q == LOAD) || (state_q == CALC);
    assign bus.done = done_q;
    assign bus.quot = quot_q;
    assign bus.rem  = rem_q;
`ifdef DIV_ZERO_CHK_EN
    assign bus.err  = err_q;
`endif
endmodule

// File: tb/tb_div_core.sv
// Randomized scoreboard bench for div_core: driver pushes expected results,
// a monitor pops and compares them whenever done rises.
module tb_div_core;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
        int           issue;
        int           lat;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_done = 1'b0;

    div_core_if #(.WIDTH(W)) bus();

    div_core #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division with the divide-by-zero convention.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int issue);
        exp_t e;
        e.issue = issue;
        e.e     = 1'b0;
        e.lat   = W + 2;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
`ifdef DIV_ZERO_CHK_EN
            e.e   = 1'b1;
            e.lat = 2;
`endif
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Called at a falling edge; init is sampled on the next rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.A    = a;
        bus.B    = b;
        bus.init = 1'b1;
        sb.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        bus.init = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
    endtask

    always @(negedge clk) begin
        if (bus.done && !prev_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("quot",    32'(bus.quot), 32'(mon_e.q));
                check("rem",     32'(bus.rem),  32'(mon_e.r));
                check("latency", 32'(cyc - mon_e.issue), 32'(mon_e.lat));
                check("busy_at_done", 32'(bus.busy), 32'd0);
`ifdef DIV_ZERO_CHK_EN
                check("err", 32'(bus.err), 32'(mon_e.e));
`endif
            end
        end
        prev_done = bus.done;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ra, rb;
        int n;
        bus.init = 1'b0;
        bus.A    = '0;
        bus.B    = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_quot", 32'(bus.quot), 32'd0);
        check("rst_rem",  32'(bus.rem),  32'd0);
`ifdef DIV_ZERO_CHK_EN
        check("rst_err",  32'(bus.err),  32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        issue(16'h0020, 16'h000F); wait_done();
        issue(16'hFFFF, 16'h0001); wait_done();
        issue(16'h0005, 16'h0007); wait_done();
        issue(16'h1234, 16'h0000); wait_done();

        // Second init while busy must be ignored, including its operands.
        issue(16'd100, 16'd7);
        repeat (4) @(negedge clk);
        check("busy_mid_calc", 32'(bus.busy), 32'd1);
        bus.A = 16'd9; bus.B = 16'd3; bus.init = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        wait_done();

        // Reset during CALC aborts with every output cleared.
        issue(16'h0020, 16'h000F);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_quot", 32'(bus.quot), 32'd0);
        check("abort_rem",  32'(bus.rem),  32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(16'h0020, 16'h000F); wait_done();

        // Back-to-back: init while done is high clears done on that edge.
        issue(16'h0064, 16'h000A);
        check("b2b_done_drop", 32'(bus.done), 32'd0);
        check("b2b_busy",      32'(bus.busy), 32'd1);
        wait_done();

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = ra + W'($urandom_range(0, 1));
                default: rb = W'($urandom);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(ra, rb);
            wait_done();
        end

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
